// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = x - y - b_in, LSB first, one bit per clock.
// Start/ready request handshake with a single-cycle done pulse once the result is loaded.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             ready,
   input  logic [WIDTH-1:0] x_val,
   input  logic [WIDTH-1:0] y_val,
   input  logic             b_in,
   output logic             busy,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [1:0]    S_IDLE  = 2'd0;
   localparam logic [1:0]    S_SHIFT = 2'd1;
   localparam logic [1:0]    S_DONE  = 2'd2;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   function automatic logic fa_parity(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   function automatic logic fa_majority(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] xs_q, xs_d;
   logic [WIDTH-1:0] ys_q, ys_d;
   logic             bor_q, bor_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             b_out_q, b_out_d;
   logic             diff_bit;
   logic             bor_next;

   // Subtraction is the adder slice with the minuend bit inverted in the majority term.
   assign diff_bit = fa_parity(xs_q[0], ys_q[0], bor_q);
   assign bor_next = fa_majority(~xs_q[0], ys_q[0], bor_q);

   // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_d = state_q;
      xs_d    = xs_q;
      ys_d    = ys_q;
      bor_d   = bor_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      b_out_d = b_out_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               xs_d    = x_val;
               ys_d    = y_val;
               bor_d   = b_in;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            res_d = {diff_bit, res_q[WIDTH-1:1]};
            xs_d  = {1'b0, xs_q[WIDTH-1:1]};
            ys_d  = {1'b0, ys_q[WIDTH-1:1]};
            bor_d = bor_next;
            cnt_d = cnt_q + CNT_ONE;
            // diff/b_out only move on the final shift so the previous result holds until then.
            if (cnt_q == CNT_LAST) begin
               diff_d  = {diff_bit, res_q[WIDTH-1:1]};
               b_out_d = bor_next;
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         xs_q    <= '0;
         ys_q    <= '0;
         bor_q   <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         xs_q    <= xs_d;
         ys_q    <= ys_d;
         bor_q   <= bor_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         b_out_q <= b_out_d;
      end
   end

   assign ready = (state_q == S_IDLE);
   assign busy  = (state_q == S_SHIFT) || (state_q == S_DONE);
   assign done  = (state_q == S_DONE);
   assign diff  = diff_q;
   assign b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 handshake/latency/hold/abort cases
// plus an exhaustive WIDTH=4 sweep against x - y - b_in.
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, b_in, ready, busy, done, b_out;
   logic [7:0] x_val, y_val, diff;
   logic       start4, b_in4, ready4, busy4, done4, b_out4;
   logic [3:0] x4, y4, diff4;

   int total = 0;
   int bad   = 0;
   logic [7:0] last_diff;
   logic       last_bout;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .ready(ready), .x_val(x_val), .y_val(y_val),
      .b_in(b_in), .busy(busy), .diff(diff), .b_out(b_out), .done(done)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .ready(ready4), .x_val(x4), .y_val(y4),
      .b_in(b_in4), .busy(busy4), .diff(diff4), .b_out(b_out4), .done(done4)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_ready", {31'd0, ready}, 32'd1);
   endtask

   // One full 8-bit operation, checking latency, result hold and return to IDLE.
   task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic b,
                      input logic [7:0] ed, input logic eb);
      wait_ready();
      x_val = x; y_val = y; b_in = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; x_val = ~x; y_val = ~y; b_in = ~b;
      check_eq("accept_ready", {31'd0, ready}, 32'd0);
      check_eq("accept_busy", {31'd0, busy}, 32'd1);
      check_eq("accept_hold", {24'd0, diff}, {24'd0, last_diff});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check_eq("done_timing", {31'd0, done}, {31'd0, (k == 8)});
         if (k < 8) begin
            check_eq("hold_diff", {24'd0, diff}, {24'd0, last_diff});
            check_eq("hold_bout", {31'd0, b_out}, {31'd0, last_bout});
         end
      end
      check_eq("diff", {24'd0, diff}, {24'd0, ed});
      check_eq("b_out", {31'd0, b_out}, {31'd0, eb});
      check_eq("done_ready", {31'd0, ready}, 32'd0);
      @(negedge clk);
      check_eq("post_ready", {31'd0, ready}, 32'd1);
      check_eq("post_done", {31'd0, done}, 32'd0);
      check_eq("post_busy", {31'd0, busy}, 32'd0);
      check_eq("post_diff", {24'd0, diff}, {24'd0, ed});
      last_diff = ed;
      last_bout = eb;
   endtask

   logic [8:0] exp_q[$];
   logic [8:0] e9;
   logic [4:0] e5;
   logic [3:0] xv, yv;
   int prev_acc, n_acc, saw_done;

   initial begin
      rst = 1'b1; start = 1'b0; b_in = 1'b0; x_val = 8'h00; y_val = 8'h00;
      start4 = 1'b0; b_in4 = 1'b0; x4 = 4'h0; y4 = 4'h0;
      repeat (2) @(negedge clk);
      check_eq("rst_ready", {31'd0, ready}, 32'd1);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_diff", {24'd0, diff}, 32'd0);
      check_eq("rst_bout", {31'd0, b_out}, 32'd0);
      rst = 1'b0;
      last_diff = 8'h00; last_bout = 1'b0;

      // Basic case, then hold check during a following underflowing op.
      op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
      op8(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1);
      op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
      op8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);

      // Start held high with new operands every cycle.
      wait_ready();
      n_acc = 0; prev_acc = 0;
      for (int c = 0; c <= 40; c++) begin
         x_val = 8'(8'h11 * c + 3);
         y_val = 8'(8'h1D * c);
         b_in  = c[0];
         start = (c <= 30);
         if (ready && start) begin
            e9 = {1'b0, x_val} - {1'b0, y_val} - {8'd0, b_in};
            exp_q.push_back(e9);
            if (n_acc > 0) check_eq("accept_gap", c - prev_acc, 32'd10);
            prev_acc = c;
            n_acc++;
         end
         @(negedge clk);
         if (done) begin
            if (exp_q.size() > 0) begin
               e9 = exp_q.pop_front();
               check_eq("stream_diff", {24'd0, diff}, {24'd0, e9[7:0]});
               check_eq("stream_bout", {31'd0, b_out}, {31'd0, e9[8]});
               last_diff = e9[7:0];
               last_bout = e9[8];
            end else begin
               check_eq("stream_extra_done", 32'd1, 32'd0);
            end
         end
      end
      start = 1'b0;
      check_eq("stream_accepts", n_acc, 32'd4);
      check_eq("stream_pending", exp_q.size(), 32'd0);

      // Reset at the 4th SHIFT edge aborts the operation.
      wait_ready();
      x_val = 8'h33; y_val = 8'h11; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_ready", {31'd0, ready}, 32'd1);
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_diff", {24'd0, diff}, 32'd0);
      check_eq("abort_bout", {31'd0, b_out}, 32'd0);
      saw_done = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) saw_done = 1;
         @(negedge clk);
      end
      check_eq("abort_no_done", saw_done, 32'd0);
      last_diff = 8'h00; last_bout = 1'b0;
      op8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);

      // start and rst on the same edge: reset wins.
      rst = 1'b1; start = 1'b1; x_val = 8'h05; y_val = 8'h01;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_eq("rst_start_ready", {31'd0, ready}, 32'd1);
      check_eq("rst_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check_eq("rst_start_idle", {31'd0, busy}, 32'd0);
      check_eq("rst_start_diff", {24'd0, diff}, 32'd0);

      // Exhaustive WIDTH=4 sweep.
      for (int xi = 0; xi < 16; xi++) begin
         for (int yi = 0; yi < 16; yi++) begin
            for (int bi = 0; bi < 2; bi++) begin
               xv = xi[3:0]; yv = yi[3:0];
               check_eq("w4_ready", {31'd0, ready4}, 32'd1);
               x4 = xv; y4 = yv; b_in4 = bi[0]; start4 = 1'b1;
               @(negedge clk);
               start4 = 1'b0; x4 = ~xv; y4 = ~yv; b_in4 = ~bi[0];
               for (int k = 1; k <= 4; k++) begin
                  @(negedge clk);
                  check_eq("w4_done", {31'd0, done4}, {31'd0, (k == 4)});
               end
               e5 = {1'b0, xv} - {1'b0, yv} - {4'd0, bi[0]};
               check_eq("w4_diff", {28'd0, diff4}, {28'd0, e5[3:0]});
               check_eq("w4_bout", {31'd0, b_out4}, {31'd0, e5[4]});
               @(negedge clk);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
